// File: rtl/text_console_if.sv
// Bundle of the keyboard stream, CPU store port, buffer write port and console status.
interface text_console_if #(
    parameter int AW = 10,
    parameter int RW = 4,
    parameter int CW = 6
);
    logic          key_valid;
    logic [7:0]    key_ascii;
    logic          key_ready;
    logic          cpu_req;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_data;
    logic          cpu_gnt;
    logic [AW-1:0] sel;
    logic [7:0]    data;
    logic          we;
    logic [RW-1:0] cur_row;
    logic [CW-1:0] cur_col;
    logic          init_done;

    modport master (
        output key_valid, key_ascii, cpu_req, cpu_addr, cpu_data,
        input  key_ready, cpu_gnt, sel, data, we, cur_row, cur_col, init_done
    );

    modport slave (
        input  key_valid, key_ascii, cpu_req, cpu_addr, cpu_data,
        output key_ready, cpu_gnt, sel, data, we, cur_row, cur_col, init_done
    );
endinterface

// File: rtl/text_console_ctrl.sv
// Cursor-tracking console writer for the display character buffer, sharing
// the single write port with a CPU store port through a round-robin arbiter.
//
// state | meaning
// INIT  | blanking every cell after reset, CPU locked out
// IDLE  | waiting for a key byte
// PUT   | one character (or backspace blank) write at the cursor
// CLEAR | blanking the row the cursor just moved onto
module text_console_ctrl #(
    parameter int         COLS  = 64,
    parameter int         ROWS  = 16,
    parameter int         AW    = 10,
    parameter logic [7:0] BLANK = 8'h20
) (
    input  logic          clk,
    input  logic          rst,
    text_console_if.slave bus
);
    localparam int RW    = $clog2(ROWS);
    localparam int CW    = $clog2(COLS);
    localparam int CELLS = COLS * ROWS;

    typedef enum logic [1:0] {INIT, IDLE, PUT, CLEAR} state_t;

    state_t        state;
    logic [AW-1:0] init_idx;
    logic [CW-1:0] clr_col;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [7:0]    put_char;
    logic          put_adv;
    logic          last_cpu;
    logic          key_ready_r;
    logic          init_done_r;
    logic          we_r;
    logic [AW-1:0] sel_r;
    logic [7:0]    data_r;

    logic          engine_pend;
    logic          cpu_gnt;
    logic          accept;
    logic          is_print;
    logic          is_newline;
    logic          is_bs;
    logic          last_col;
    logic [RW-1:0] row_next;

    function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] r, input logic [CW-1:0] c);
        return AW'(int'(r) * COLS + int'(c));
    endfunction

    // When both sides want the port, whoever lost last time wins now.
    assign engine_pend = (state == PUT) || (state == CLEAR);
    assign cpu_gnt     = bus.cpu_req && (state != INIT) && !(engine_pend && last_cpu);
    assign accept      = bus.key_valid && key_ready_r;
    assign is_print    = (bus.key_ascii >= 8'h20) && (bus.key_ascii <= 8'h7E);
    assign is_newline  = (bus.key_ascii == 8'h0A) || (bus.key_ascii == 8'h0D);
    assign is_bs       = (bus.key_ascii == 8'h08);
    assign last_col    = (col == CW'(COLS - 1));
    assign row_next    = (row == RW'(ROWS - 1)) ? '0 : row + RW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= INIT;
            init_idx    <= '0;
            clr_col     <= '0;
            row         <= '0;
            col         <= '0;
            put_char    <= '0;
            put_adv     <= 1'b0;
            last_cpu    <= 1'b0;
            key_ready_r <= 1'b0;
            init_done_r <= 1'b0;
            we_r        <= 1'b0;
            sel_r       <= '0;
            data_r      <= '0;
        end else begin
            we_r <= 1'b0;
            if (cpu_gnt) begin
                we_r     <= 1'b1;
                sel_r    <= bus.cpu_addr;
                data_r   <= bus.cpu_data;
                last_cpu <= 1'b1;
            end
            case (state)
                INIT: begin
                    we_r     <= 1'b1;
                    sel_r    <= init_idx;
                    data_r   <= BLANK;
                    last_cpu <= 1'b0;
                    init_idx <= init_idx + AW'(1);
                    if (init_idx == AW'(CELLS - 1)) begin
                        init_idx    <= '0;
                        state       <= IDLE;
                        key_ready_r <= 1'b1;
                        init_done_r <= 1'b1;
                    end
                end
                IDLE: begin
                    if (accept) begin
                        if (is_print) begin
                            put_char    <= bus.key_ascii;
                            put_adv     <= 1'b1;
                            state       <= PUT;
                            key_ready_r <= 1'b0;
                        end else if (is_newline) begin
                            col         <= '0;
                            row         <= row_next;
                            clr_col     <= '0;
                            state       <= CLEAR;
                            key_ready_r <= 1'b0;
                        end else if (is_bs && (col != '0)) begin
                            col         <= col - CW'(1);
                            put_char    <= BLANK;
                            put_adv     <= 1'b0;
                            state       <= PUT;
                            key_ready_r <= 1'b0;
                        end
                    end
                end
                PUT: begin
                    if (!cpu_gnt) begin
                        we_r     <= 1'b1;
                        sel_r    <= cell_addr(row, col);
                        data_r   <= put_char;
                        last_cpu <= 1'b0;
                        if (put_adv && last_col) begin
                            col     <= '0;
                            row     <= row_next;
                            clr_col <= '0;
                            state   <= CLEAR;
                        end else begin
                            if (put_adv) col <= col + CW'(1);
                            state       <= IDLE;
                            key_ready_r <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    if (!cpu_gnt) begin
                        we_r     <= 1'b1;
                        sel_r    <= cell_addr(row, clr_col);
                        data_r   <= BLANK;
                        last_cpu <= 1'b0;
                        clr_col  <= clr_col + CW'(1);
                        if (clr_col == CW'(COLS - 1)) begin
                            state       <= IDLE;
                            key_ready_r <= 1'b1;
                        end
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

    assign bus.cpu_gnt   = cpu_gnt;
    assign bus.key_ready = key_ready_r;
    assign bus.init_done = init_done_r;
    assign bus.we        = we_r;
    assign bus.sel       = sel_r;
    assign bus.data      = data_r;
    assign bus.cur_row   = row;
    assign bus.cur_col   = col;
endmodule

// File: tb/tb_text_console_ctrl.sv
// Directed and randomized bench for text_console_ctrl against a screen-level model.
module tb_text_console_ctrl;
    localparam int COLS  = 64;
    localparam int ROWS  = 16;
    localparam int CELLS = COLS * ROWS;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    text_console_if #(.AW(10), .RW(4), .CW(6)) bus ();

    text_console_ctrl #(.COLS(COLS), .ROWS(ROWS), .AW(10), .BLANK(8'h20)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    logic [17:0] wlog[$];
    logic [7:0]  shadow[CELLS];
    logic [7:0]  mscr[CELLS];
    int          mrow, mcol;

    always @(negedge clk) begin
        if (bus.we === 1'b1) begin
            wlog.push_back({bus.sel, bus.data});
            shadow[bus.sel] = bus.data;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < CELLS; i++) mscr[i] = 8'h20;
        mrow = 0;
        mcol = 0;
    endtask

    task automatic model_newline();
        mcol = 0;
        mrow = (mrow + 1) % ROWS;
        for (int c = 0; c < COLS; c++) mscr[mrow * COLS + c] = 8'h20;
    endtask

    task automatic model_key(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            mscr[mrow * COLS + mcol] = b;
            if (mcol < COLS - 1) mcol++;
            else model_newline();
        end else if (b == 8'h0A || b == 8'h0D) begin
            model_newline();
        end else if (b == 8'h08 && mcol > 0) begin
            mcol--;
            mscr[mrow * COLS + mcol] = 8'h20;
        end
    endtask

    task automatic key(input logic [7:0] b, output int low);
        int w = 0;
        while (bus.key_ready !== 1'b1 && w < 500) begin step(); w++; end
        chk("key_ready_wait_timeout", (w < 500), 1);
        bus.key_valid = 1'b1;
        bus.key_ascii = b;
        step();
        bus.key_valid = 1'b0;
        low = 0;
        while (bus.key_ready !== 1'b1 && low < 500) begin step(); low++; end
        chk("key_done_timeout", (low < 500), 1);
        model_key(b);
    endtask

    task automatic cpu_write(input logic [9:0] a, input logic [7:0] d);
        int w = 0;
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = a;
        bus.cpu_data = d;
        #1;
        while (bus.cpu_gnt !== 1'b1 && w < 500) begin @(negedge clk); #2; w++; end
        chk("cpu_gnt_timeout", (w < 500), 1);
        @(negedge clk);
        #1;
        bus.cpu_req = 1'b0;
        mscr[a] = d;
    endtask

    task automatic wait_init();
        int w = 0;
        while (bus.init_done !== 1'b1 && w < 2000) begin step(); w++; end
        chk("init_done_timeout", (w < 2000), 1);
    endtask

    task automatic check_init_log(input string tag);
        int err = 0;
        for (int i = 0; i < CELLS; i++)
            if (i >= wlog.size() || wlog[i] !== {10'(i), 8'h20}) err++;
        chk({tag, "_seq_errors"}, err, 0);
        chk({tag, "_count"}, wlog.size(), CELLS);
    endtask

    task automatic check_screen(input string tag);
        int err = 0;
        for (int i = 0; i < CELLS; i++) if (shadow[i] !== mscr[i]) err++;
        chk({tag, "_screen_errors"}, err, 0);
        chk({tag, "_cur_row"}, bus.cur_row, mrow);
        chk({tag, "_cur_col"}, bus.cur_col, mcol);
    endtask

    initial begin
        int low, low2, err, r, g1, g2, g3;
        logic [7:0]  b;
        logic [17:0] exp_q[$];

        bus.key_valid = 1'b0;
        bus.key_ascii = 8'h00;
        bus.cpu_req   = 1'b1;
        bus.cpu_addr  = 10'h0AB;
        bus.cpu_data  = 8'h77;
        repeat (3) step();

        // reset state, with a CPU request pending
        chk("rst_we", bus.we, 0);
        chk("rst_sel", bus.sel, 0);
        chk("rst_data", bus.data, 0);
        chk("rst_key_ready", bus.key_ready, 0);
        chk("rst_cpu_gnt", bus.cpu_gnt, 0);
        chk("rst_init_done", bus.init_done, 0);
        chk("rst_cursor", {bus.cur_row, bus.cur_col}, 0);
        bus.cpu_req = 1'b0;
        wlog.delete();
        rst = 1'b1;

        // power-up clear
        wait_init();
        step();
        check_init_log("init");
        chk("init_key_ready", bus.key_ready, 1);
        chk("init_cursor", {bus.cur_row, bus.cur_col}, 0);
        model_reset();

        // two printable characters
        wlog.delete();
        key(8'h41, low);
        key(8'h42, low2);
        chk("ab_count", wlog.size(), 2);
        chk("ab_w0", wlog.size() > 0 ? wlog[0] : 18'h3FFFF, {10'd0, 8'h41});
        chk("ab_w1", wlog.size() > 1 ? wlog[1] : 18'h3FFFF, {10'd1, 8'h42});
        chk("ab_low_a", low, 1);
        chk("ab_low_b", low2, 1);
        chk("ab_cursor", {bus.cur_row, bus.cur_col}, {4'd0, 6'd2});

        // wrap at the last cell of the last row
        repeat (15) key(8'h0A, low);
        repeat (63) key(8'($urandom_range(32, 126)), low);
        chk("pre_wrap_cursor", {bus.cur_row, bus.cur_col}, {4'd15, 6'd63});
        wlog.delete();
        key(8'h5A, low);
        chk("wrap_count", wlog.size(), 65);
        chk("wrap_char", wlog.size() > 0 ? wlog[0] : 18'h3FFFF, {10'd1023, 8'h5A});
        err = 0;
        for (int i = 1; i <= COLS; i++)
            if (i >= wlog.size() || wlog[i] !== {10'(i - 1), 8'h20}) err++;
        chk("wrap_clear_errors", err, 0);
        chk("wrap_cursor", {bus.cur_row, bus.cur_col}, 0);

        // carriage return mid-row, then backspace at column 0
        key(8'h0A, low);
        key(8'h0A, low);
        repeat (5) key(8'($urandom_range(32, 126)), low);
        wlog.delete();
        key(8'h0D, low);
        chk("cr_count", wlog.size(), 64);
        err = 0;
        for (int i = 0; i < COLS; i++)
            if (i >= wlog.size() || wlog[i] !== {10'(192 + i), 8'h20}) err++;
        chk("cr_clear_errors", err, 0);
        chk("cr_cursor", {bus.cur_row, bus.cur_col}, {4'd3, 6'd0});
        wlog.delete();
        key(8'h08, low);
        chk("bs_col0_writes", wlog.size(), 0);
        chk("bs_col0_low", low, 0);
        chk("bs_col0_cursor", {bus.cur_row, bus.cur_col}, {4'd3, 6'd0});

        // CPU contending with a row clear
        wlog.delete();
        bus.key_valid = 1'b1;
        bus.key_ascii = 8'h0A;
        step();
        bus.key_valid = 1'b0;
        model_key(8'h0A);
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 10'h155;
        bus.cpu_data = 8'h33;
        #1 g1 = bus.cpu_gnt;
        step();
        bus.cpu_addr = 10'h2AA;
        bus.cpu_data = 8'h5C;
        #1 g2 = bus.cpu_gnt;
        step();
        #1 g3 = bus.cpu_gnt;
        step();
        bus.cpu_req = 1'b0;
        mscr[10'h155] = 8'h33;
        mscr[10'h2AA] = 8'h5C;
        low = 0;
        while (bus.key_ready !== 1'b1 && low < 500) begin step(); low++; end
        chk("arb_done_timeout", (low < 500), 1);
        chk("arb_g1_cpu", g1, 1);
        chk("arb_g2_console", g2, 0);
        chk("arb_g3_cpu", g3, 1);
        exp_q = '{{10'h155, 8'h33}, {10'd256, 8'h20}, {10'h2AA, 8'h5C}};
        for (int i = 257; i < 320; i++) exp_q.push_back({10'(i), 8'h20});
        chk("arb_count", wlog.size(), exp_q.size());
        err = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= wlog.size() || wlog[i] !== exp_q[i]) err++;
        chk("arb_seq_errors", err, 0);
        check_screen("directed");

        // randomized keys and idle CPU stores against the screen model
        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 9) == 0)
                cpu_write(10'($urandom_range(0, CELLS - 1)), 8'($urandom_range(0, 255)));
            r = $urandom_range(0, 99);
            if (r < 70)      b = 8'($urandom_range(32, 126));
            else if (r < 76) b = 8'h0A;
            else if (r < 80) b = 8'h0D;
            else if (r < 90) b = 8'h08;
            else if (r < 95) b = 8'($urandom_range(0, 31));
            else             b = 8'($urandom_range(127, 255));
            key(b, low);
        end
        check_screen("random");

        // reset in the middle of a row clear
        bus.key_valid = 1'b1;
        bus.key_ascii = 8'h0A;
        step();
        bus.key_valid = 1'b0;
        repeat (3) step();
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 10'h011;
        bus.cpu_data = 8'h99;
        rst = 1'b0;
        #1;
        chk("midrst_we", bus.we, 0);
        chk("midrst_sel", bus.sel, 0);
        chk("midrst_data", bus.data, 0);
        chk("midrst_key_ready", bus.key_ready, 0);
        chk("midrst_cpu_gnt", bus.cpu_gnt, 0);
        chk("midrst_init_done", bus.init_done, 0);
        chk("midrst_cursor", {bus.cur_row, bus.cur_col}, 0);
        bus.cpu_req = 1'b0;
        step();
        wlog.delete();
        step();
        rst = 1'b1;
        wait_init();
        step();
        check_init_log("reinit");
        model_reset();
        check_screen("reinit");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
